fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter N, default 64, address/PC width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have PCSrc_F  input  1  redirect request from the memory stage (taken branch).
REQ-006 SHALL have PCBranch_F  input  N  redirect target PC.
REQ-007 SHALL have imem_req_valid  output  1  fetch request valid.
REQ-008 SHALL have imem_req_ready  input  1  instruction memory accepts request.
REQ-009 SHALL have imem_addr  output  N  fetch byte address.
REQ-010 SHALL have imem_rsp_valid  input  1  response valid; responses return in request order, latency >=1 cycle.
REQ-011 SHALL have imem_rsp_data  input  32  fetched instruction word.
REQ-012 SHALL have instr_valid  output  1  queue head valid toward IF_ID.
REQ-013 SHALL have instr_ready  input  1  IF_ID/decode accepts head (low = stall).
REQ-014 SHALL have instr_D  output  32  head instruction.
REQ-015 SHALL have instr_pc  output  N  PC of head instruction.

Function
REQ-016 SHALL hold fetch PC pc_q; imem_addr = pc_q; pc_q advances by 4 on each accepted request (valid & ready), wrapping modulo 2^N.
REQ-017 SHALL assert imem_req_valid only when count + outstanding < DEPTH and PCSrc_F is low (credit rule; queue can never overflow).
REQ-018 SHALL track outstanding (accepted, unanswered requests), 0..DEPTH; +1 on accept, -1 on response, unchanged on both together.
REQ-019 SHALL push each non-discarded response into the queue as {rsp_pc_q, imem_rsp_data}; rsp_pc_q advances by 4 per push.
REQ-020 SHALL present the head combinationally from queue storage: instr_valid = count != 0 and PCSrc_F low; pop on instr_valid & instr_ready.
REQ-021 SHALL, on simultaneous push and pop, keep count unchanged and preserve FIFO order; a response written in cycle t is visible no earlier than t+1 (no bypass).
REQ-022 SHALL, on PCSrc_F high in cycle t: empty the queue, set pc_q and rsp_pc_q to {PCBranch_F[N-1:2],2'b00}, set discard = outstanding - imem_rsp_valid, drop any response in cycle t, issue no request in t.
REQ-023 SHALL drop responses while discard != 0, decrementing discard per dropped response; dropped data never reaches the queue.
REQ-024 SHALL treat a redirect while discard != 0 by recomputing discard from outstanding (REQ-022); the newest target wins.
REQ-025 SHALL give redirect-to-instruction latency: request for target at t+1; with 1-cycle memory, instr_valid with that PC at t+3.
REQ-026 SHALL hold imem_addr stable while imem_req_valid is high and imem_req_ready is low, unless redirected.
REQ-027 SHALL ignore instr_ready when instr_valid is low.

Reset
REQ-028 SHALL, while reset is high, force pc_q = 0, rsp_pc_q = 0, count = 0, outstanding = 0, discard = 0.
REQ-029 SHALL drive imem_req_valid = 0, imem_addr = 0, instr_valid = 0, instr_D = 0, instr_pc = 0 during reset and in the first cycle after it.
REQ-030 SHALL require the memory to drop in-flight responses on reset; reset mid-operation discards all queued entries with no partial state retained.

Structure
REQ-031 SHALL place in a shared package: fetch entry struct {pc N bits, instr 32 bits}, constant INSTR_BYTES = 4, and the PC alignment mask.
REQ-032 SHALL instantiate one sub-module fifo_sync (parameterised width/depth, push/pop/flush, count output) for entry storage; counters and redirect logic remain in fetch_queue.

Verification
REQ-033 Reset, then 1-cycle memory, instr_ready=1 -> instr_pc sequence 0,4,8,12 from cycle 3 onward, one per cycle, no gaps.
REQ-034 instr_ready=0 for 10 cycles -> count reaches 4, imem_req_valid low, outstanding 0; release -> PCs 0,4,8,12,16 in order, none lost or duplicated.
REQ-035 PCSrc_F=1, PCBranch_F=0x100 at t, 2 requests outstanding -> imem_addr=0x100 at t+1, both stale responses dropped, first instr_pc=0x100.
REQ-036 PCBranch_F=0x203 -> fetch address 0x200; PC 0xFFFF_FFFF_FFFF_FFFC fetch -> next address 0.
REQ-037 Back-to-back redirects to 0x40 then 0x80 in consecutive cycles -> no instruction from 0x40 delivered; first delivered PC 0x80.
REQ-038 Reset asserted with full queue and 3 outstanding -> all outputs 0 next cycle; fetching restarts at PC 0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Shared types and constants for the instruction fetch queue.
//   - fetch_entry_t : one queue entry, {pc, instr}. The pc field is sized for
//                     the widest supported PC (64 bits). Narrower PCs are
//                     zero-extended on the way in and truncated on the way out.
//   - INSTR_BYTES   : byte stride between consecutive instructions.
//   - PC_ALIGN_MASK : clears the low address bits so every PC is word aligned.
package fetch_queue_pkg;

  localparam int unsigned PC_MAX_W    = 64;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [PC_MAX_W-1:0] PC_ALIGN_MASK = ~(PC_MAX_W'(INSTR_BYTES - 1));

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue_fifo.sv
// fifo_sync
//   Synchronous FIFO with power-of-two depth and a synchronous flush.
//   The read data is the head entry, taken straight from storage, so a word
//   written in cycle t is readable no earlier than cycle t+1.
//   Ports:
//     clk_i, reset_i : clock, synchronous active-high reset (empties the FIFO)
//     push_i/wdata_i : write one entry (ignored when full, unless popping too)
//     pop_i          : remove the head entry (ignored when empty)
//     flush_i        : empty the FIFO; wins over push/pop in the same cycle
//     rdata_o        : head entry (contents undefined when count_o == 0)
//     count_o        : number of stored entries, 0..DEPTH
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    // A full FIFO may still accept a write when the head leaves in the same cycle.
    do_push  = push_i && ((count_q != FULL_C) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q gates whether any slot is meaningful.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !reset_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch front end: issues sequential word fetches to an
//   in-order instruction memory, buffers the returned words with their PCs
//   in a small FIFO, and presents the head to decode. A redirect (taken
//   branch) flushes the FIFO, retargets both PCs and discards the responses
//   still in flight.
//
//   Handshakes (both directions): a transfer happens in a cycle where valid
//   and ready are both high at the rising edge. valid never depends on ready
//   of the same interface. While a request is stalled (valid high, ready low)
//   the address is held unless a redirect arrives.
//
//   Ports:
//     clk, reset                      : clock, synchronous active-high reset
//     PCSrc_F, PCBranch_F             : redirect request and target PC
//     imem_req_valid/ready, imem_addr : fetch request channel
//     imem_rsp_valid, imem_rsp_data   : in-order response channel (latency >= 1)
//     instr_valid/ready, instr_D,
//     instr_pc                        : queue head toward decode
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCSrc_F,
  input  logic [N-1:0] PCBranch_F,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr_D,
  output logic [N-1:0] instr_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [N-1:0]  pc_q, pc_d;
  logic [N-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          started_q, started_d;

  logic [CW-1:0] count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [N-1:0]  target_pc;
  logic          credit_ok;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          show_head;

  assign target_pc = PCBranch_F & PC_ALIGN_MASK[N-1:0];

  // Every queued entry and every in-flight request holds one slot, so the
  // FIFO can never be asked to take more than it has room for.
  assign credit_ok = ({1'b0, count} + {1'b0, outst_q}) < DEPTH_C;

  // started_q keeps the request channel quiet in the first cycle after reset.
  assign imem_req_valid = started_q && credit_ok && !PCSrc_F && !reset;
  assign imem_addr      = reset ? '0 : pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign show_head   = (count != '0) && !reset;
  assign instr_valid = show_head && !PCSrc_F;
  assign instr_D     = show_head ? head.instr : '0;
  assign instr_pc    = show_head ? head.pc[N-1:0] : '0;
  assign pop         = instr_valid && instr_ready;

  // Responses in a redirect cycle, or while stale requests are draining,
  // never reach the FIFO.
  assign push = imem_rsp_valid && !PCSrc_F && (discard_q == '0);

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = PC_MAX_W'(rsp_pc_q);
    push_entry.instr = imem_rsp_data;
  end

  always_comb begin
    pc_d      = pc_q;
    rsp_pc_d  = rsp_pc_q;
    discard_d = discard_q;
    started_d = 1'b1;
    outst_d   = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (PCSrc_F) begin
      pc_d      = target_pc;
      rsp_pc_d  = target_pc;
      // Everything still in flight belongs to the old path; a response
      // arriving this very cycle is already dropped by the push gate.
      discard_d = outst_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + N'(INSTR_BYTES);
      if (push)     rsp_pc_d = rsp_pc_q + N'(INSTR_BYTES);
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      rsp_pc_q  <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      rsp_pc_q  <= rsp_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      started_q <= started_d;
    end
  end

  fifo_sync #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (PCSrc_F),
    .wdata_i (push_entry),
    .rdata_o (head),
    .count_o (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Bench for fetch_queue: an in-order memory model with programmable
//   latency, a scoreboard of expected {pc, instr} deliveries, a start-up
//   vector table, directed redirect/stall/reset sequences and a random run.
module tb_fetch_queue;

  localparam int N     = 64;
  localparam int DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         PCSrc_F;
  logic [N-1:0] PCBranch_F;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [N-1:0] imem_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr_D;
  logic [N-1:0] instr_pc;

  always #5 clk = ~clk;

  fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .PCSrc_F        (PCSrc_F),
    .PCBranch_F     (PCBranch_F),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_D        (instr_D),
    .instr_pc       (instr_pc)
  );

  // ---------------- models and scoreboard state ----------------
  typedef struct {
    logic [N-1:0] addr;
    int           due;
  } mem_t;

  mem_t          mem_q[$];
  int            last_due;
  logic [N+31:0] exp_q[$];
  logic [N-1:0]  exp_fetch;

  int           cyc;
  int           n_checks;
  int           n_pass;
  int           n_pops;
  logic [N-1:0] first_pop_pc;
  bit           post_rst;
  bit           prev_stalled;
  logic [N-1:0] prev_addr;

  // stimulus knobs, applied by cycle()
  logic         drv_rst;
  logic         drv_pcsrc;
  logic [N-1:0] drv_target;
  logic         drv_iready;
  logic         drv_rready;
  int           drv_lat;

  function automatic logic [31:0] data_of(logic [N-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0001;
  endfunction

  function automatic void check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle();
    mem_t          m;
    logic [N+31:0] e;
    @(negedge clk);
    reset          = drv_rst;
    PCSrc_F        = drv_pcsrc;
    PCBranch_F     = drv_target;
    instr_ready    = drv_iready;
    imem_req_ready = drv_rready;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (drv_rst) begin
      mem_q.delete();
      last_due = 0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data_of(m.addr);
    end
    #1;
    if (drv_rst) begin
      check("rst_req_valid",   N'(imem_req_valid), '0);
      check("rst_imem_addr",   imem_addr, '0);
      check("rst_instr_valid", N'(instr_valid), '0);
      check("rst_instr_D",     N'(instr_D), '0);
      check("rst_instr_pc",    instr_pc, '0);
      exp_q.delete();
      exp_fetch    = '0;
      post_rst     = 1'b1;
      prev_stalled = 1'b0;
    end else begin
      if (post_rst) begin
        check("post_rst_req_valid",   N'(imem_req_valid), '0);
        check("post_rst_imem_addr",   imem_addr, '0);
        check("post_rst_instr_valid", N'(instr_valid), '0);
        check("post_rst_instr_D",     N'(instr_D), '0);
        check("post_rst_instr_pc",    instr_pc, '0);
        post_rst = 1'b0;
      end
      if (prev_stalled) check("stall_addr_hold", imem_addr, prev_addr);
      if (drv_pcsrc) begin
        check("redir_no_instr_valid", N'(instr_valid), '0);
        check("redir_no_req", N'(imem_req_valid), '0);
      end
      if (instr_valid && instr_ready) begin
        if (n_pops == 0) first_pop_pc = instr_pc;
        n_pops++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_pop: got pc 0x%0h, expected no instruction (cycle %0d)", instr_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", instr_pc, e[N+31:32]);
          check("pop_instr", N'(instr_D), N'(e[31:0]));
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        check("fetch_addr", imem_addr, exp_fetch);
        m.addr = imem_addr;
        m.due  = cyc + drv_lat;
        if (m.due < last_due) m.due = last_due;
        last_due = m.due;
        mem_q.push_back(m);
        exp_q.push_back({imem_addr, data_of(imem_addr)});
        exp_fetch = exp_fetch + N'(4);
        check("credit_limit", N'(exp_q.size() <= DEPTH), N'(1));
      end
      if (drv_pcsrc) begin
        exp_q.delete();
        exp_fetch = drv_target & ~64'h3;
      end
      prev_stalled = imem_req_valid && !imem_req_ready && !drv_pcsrc;
      prev_addr    = imem_addr;
    end
    cyc++;
  endtask

  task automatic do_reset();
    drv_rst   = 1'b1;
    drv_pcsrc = 1'b0;
    repeat (2) cycle();
    drv_rst = 1'b0;
  endtask

  task automatic redirect(logic [N-1:0] tgt);
    drv_pcsrc  = 1'b1;
    drv_target = tgt;
    cycle();
    drv_pcsrc = 1'b0;
  endtask

  // Runs until at least one instruction is delivered or the budget expires.
  task automatic wait_first_pop(string name, int budget);
    for (int i = 0; i < budget && n_pops == 0; i++) cycle();
    check({name, "_delivered"}, N'(n_pops != 0), N'(1));
  endtask

  // ---------------- start-up vector table ----------------
  typedef struct {
    logic         iready;
    logic         exp_rv;
    logic [N-1:0] exp_addr;
    logic         exp_iv;
    logic [N-1:0] exp_pc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    reset = 1'b1; PCSrc_F = 1'b0; PCBranch_F = '0; instr_ready = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    drv_rst = 1'b1; drv_pcsrc = 1'b0; drv_target = '0; drv_iready = 1'b1;
    drv_rready = 1'b1; drv_lat = 1;
    cyc = 0; n_checks = 0; n_pass = 0; n_pops = 0; first_pop_pc = '0;
    post_rst = 1'b0; prev_stalled = 1'b0; prev_addr = '0;
    exp_fetch = '0; last_due = 0;

    // cycle 0 is the first cycle with reset low
    tbl[0] = '{1'b1, 1'b0, 64'd0,  1'b0, 64'd0};
    tbl[1] = '{1'b1, 1'b1, 64'd0,  1'b0, 64'd0};
    tbl[2] = '{1'b1, 1'b1, 64'd4,  1'b0, 64'd0};
    tbl[3] = '{1'b1, 1'b1, 64'd8,  1'b1, 64'd0};
    tbl[4] = '{1'b1, 1'b1, 64'd12, 1'b1, 64'd4};
    tbl[5] = '{1'b1, 1'b1, 64'd16, 1'b1, 64'd8};
    tbl[6] = '{1'b1, 1'b1, 64'd20, 1'b1, 64'd12};

    // start-up with 1-cycle memory
    drv_lat = 1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drv_iready = tbl[i].iready;
      cycle();
      check("tbl_req_valid",   N'(imem_req_valid), N'(tbl[i].exp_rv));
      check("tbl_imem_addr",   imem_addr, tbl[i].exp_addr);
      check("tbl_instr_valid", N'(instr_valid), N'(tbl[i].exp_iv));
      if (tbl[i].exp_iv) check("tbl_instr_pc", instr_pc, tbl[i].exp_pc);
    end

    // decode stall fills the queue, then drains in order
    do_reset();
    drv_iready = 1'b0;
    repeat (10) cycle();
    check("stall_req_valid_low", N'(imem_req_valid), '0);
    check("stall_head_valid",    N'(instr_valid), N'(1));
    check("stall_head_pc",       instr_pc, '0);
    drv_iready = 1'b1;
    n_pops = 0;
    repeat (5) cycle();
    check("stall_release_pops", N'(n_pops), N'(5));

    // redirect with two requests in flight (3-cycle memory)
    drv_lat = 3;
    do_reset();
    repeat (3) cycle();
    redirect(64'h100);
    n_pops = 0;
    cycle();
    check("redir_addr_next", imem_addr, 64'h100);
    check("redir_req_next",  N'(imem_req_valid), N'(1));
    wait_first_pop("redir_0x100", 20);
    check("redir_first_pc", first_pop_pc, 64'h100);

    // target alignment and address wrap
    drv_lat = 1;
    redirect(64'h203);
    cycle();
    check("align_addr", imem_addr, 64'h200);
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    cycle();
    check("wrap_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();
    check("wrap_addr_zero", imem_addr, '0);
    repeat (6) cycle();

    // back-to-back redirects: newest target wins
    redirect(64'h40);
    redirect(64'h80);
    n_pops = 0;
    wait_first_pop("b2b", 20);
    check("b2b_first_pc", first_pop_pc, 64'h80);

    // reset mid-operation with queued entries and requests in flight
    drv_lat = 5;
    drv_iready = 1'b0;
    repeat (8) cycle();
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
    drv_iready = 1'b1;
    drv_lat = 1;
    n_pops = 0;
    wait_first_pop("rst_restart", 20);
    check("rst_restart_pc", first_pop_pc, '0);

    // randomized traffic against the scoreboard
    for (int i = 0; i < 1500; i++) begin
      drv_iready = ($urandom_range(0, 9) < 7);
      drv_rready = ($urandom_range(0, 9) < 7);
      drv_lat    = $urandom_range(1, 4);
      drv_rst    = ($urandom_range(0, 299) == 0);
      drv_pcsrc  = !drv_rst && ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 3))
        0:       drv_target = {$urandom, $urandom};
        1:       drv_target = 64'hFFFF_FFFF_FFFF_FFF0 + N'($urandom_range(0, 15));
        default: drv_target = N'($urandom_range(0, 4095));
      endcase
      cycle();
    end

    // drain: no new requests, everything in flight must come out
    drv_rst = 1'b0; drv_pcsrc = 1'b0; drv_rready = 1'b0; drv_iready = 1'b1;
    repeat (30) cycle();
    check("drain_exp_q_empty", N'(exp_q.size()), '0);
    check("drain_mem_empty",   N'(mem_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
